// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   Multi-ported register file with one write port, two independent
//   latency-1 read ports, a per-register "written since reset" bitmap and a
//   dump engine. The dump engine streams every register out, in index order,
//   over a valid/ready handshake.
//
//   Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a write
//   on the same edge as a read or a dump load of that address forwards
//   wr_data. When it is undefined, the pre-write value is returned.
//
// Ports
//   clk, reset_n               clock, async active-low reset
//   wr_addr/wr_enable/wr_data  write port
//   rd_{a,b}_req/addr          read requests
//   rd_{a,b}_data/valid        registered read data, one-cycle valid pulse
//   written                    per-register written-since-reset bitmap
//   dump_start/dump_ready      dump kick-off and downstream accept
//   dump_valid/data/idx        dump beat (held stable until accepted)
//   dump_busy/dump_done        dump in progress / one-cycle completion pulse
// ----------------------------------------------------------------------------
module register_file #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [ADDR_WIDTH-1:0]       wr_addr,
   input  logic                        wr_enable,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   input  logic                        rd_a_req,
   input  logic [ADDR_WIDTH-1:0]       rd_a_addr,
   input  logic                        rd_b_req,
   input  logic [ADDR_WIDTH-1:0]       rd_b_addr,
   output logic [DATA_WIDTH-1:0]       rd_a_data,
   output logic                        rd_a_valid,
   output logic [DATA_WIDTH-1:0]       rd_b_data,
   output logic                        rd_b_valid,
   output logic [2**ADDR_WIDTH-1:0]    written,
   input  logic                        dump_start,
   input  logic                        dump_ready,
   output logic                        dump_valid,
   output logic [DATA_WIDTH-1:0]       dump_data,
   output logic [ADDR_WIDTH-1:0]       dump_idx,
   output logic                        dump_busy,
   output logic                        dump_done
);

   localparam int unsigned           DEPTH    = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } dump_state_e;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]      written_q, written_d;

   logic [DATA_WIDTH-1:0] rd_a_data_q, rd_a_data_d;
   logic [DATA_WIDTH-1:0] rd_b_data_q, rd_b_data_d;
   logic                  rd_a_valid_q, rd_a_valid_d;
   logic                  rd_b_valid_q, rd_b_valid_d;

   dump_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] dump_idx_q, dump_idx_d;
   logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
   logic                  dump_valid_q, dump_valid_d;
   logic                  dump_busy_q, dump_busy_d;
   logic                  dump_done_q, dump_done_d;

   // Value seen by a read or a dump load of slot a at the current edge.
   function automatic logic [DATA_WIDTH-1:0] read_slot(input logic [ADDR_WIDTH-1:0] a);
`ifdef REGFILE_BYPASS_EN
      if (wr_enable && (wr_addr == a)) begin
         return wr_data;
      end
`endif
      return regs_q[a];
   endfunction

   // Write port and written-since-reset bitmap.
   always_comb begin : write_path
      regs_d    = regs_q;
      written_d = written_q;
      if (wr_enable) begin
         regs_d[wr_addr]    = wr_data;
         written_d[wr_addr] = 1'b1;
      end
   end

   // Read ports: data holds its last value when no request is made.
   always_comb begin : read_path
      rd_a_valid_d = rd_a_req;
      rd_b_valid_d = rd_b_req;
      rd_a_data_d  = rd_a_data_q;
      rd_b_data_d  = rd_b_data_q;
      if (rd_a_req) begin
         rd_a_data_d = read_slot(rd_a_addr);
      end
      if (rd_b_req) begin
         rd_b_data_d = read_slot(rd_b_addr);
      end
   end

   // Dump engine next state. Beat data is captured at load time, so a later
   // rewrite of the slot cannot disturb a beat that is waiting for ready.
   always_comb begin : dump_fsm
      state_d      = state_q;
      dump_idx_d   = dump_idx_q;
      dump_data_d  = dump_data_q;
      dump_valid_d = 1'b0;
      dump_busy_d  = 1'b0;
      dump_done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (dump_start) begin
               state_d     = SEND;
               dump_idx_d  = '0;
               dump_data_d = read_slot(ADDR_WIDTH'(0));
            end
         end
         SEND: begin
            if (dump_ready) begin
               if (dump_idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  dump_idx_d  = ADDR_WIDTH'(dump_idx_q + 1'b1);
                  dump_data_d = read_slot(ADDR_WIDTH'(dump_idx_q + 1'b1));
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Status flags are registered copies of the upcoming state.
      dump_valid_d = (state_d == SEND);
      dump_busy_d  = (state_d != IDLE);
      dump_done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         written_q    <= '0;
         rd_a_data_q  <= '0;
         rd_b_data_q  <= '0;
         rd_a_valid_q <= 1'b0;
         rd_b_valid_q <= 1'b0;
         state_q      <= IDLE;
         dump_idx_q   <= '0;
         dump_data_q  <= '0;
         dump_valid_q <= 1'b0;
         dump_busy_q  <= 1'b0;
         dump_done_q  <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         written_q    <= written_d;
         rd_a_data_q  <= rd_a_data_d;
         rd_b_data_q  <= rd_b_data_d;
         rd_a_valid_q <= rd_a_valid_d;
         rd_b_valid_q <= rd_b_valid_d;
         state_q      <= state_d;
         dump_idx_q   <= dump_idx_d;
         dump_data_q  <= dump_data_d;
         dump_valid_q <= dump_valid_d;
         dump_busy_q  <= dump_busy_d;
         dump_done_q  <= dump_done_d;
      end
   end

   assign rd_a_data  = rd_a_data_q;
   assign rd_b_data  = rd_b_data_q;
   assign rd_a_valid = rd_a_valid_q;
   assign rd_b_valid = rd_b_valid_q;
   assign written    = written_q;
   assign dump_valid = dump_valid_q;
   assign dump_data  = dump_data_q;
   assign dump_idx   = dump_idx_q;
   assign dump_busy  = dump_busy_q;
   assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
//   Directed bench for register_file (default 8 x 8-bit). A behavioural model
//   (array of registers, integer dump position) predicts every output, and a
//   negedge compare process checks the DUT against it. Literal expectations
//   in the directed sequence pin the model itself.
// ----------------------------------------------------------------------------
module tb_register_file;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

`ifdef REGFILE_BYPASS_EN
   localparam logic [7:0] EXP_RAW_B  = 8'h22;
   localparam logic [7:0] EXP_LOAD_3 = 8'h33;
`else
   localparam logic [7:0] EXP_RAW_B  = 8'h11;
   localparam logic [7:0] EXP_LOAD_3 = 8'h13;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] wr_addr;
   logic          wr_enable;
   logic [DW-1:0] wr_data;
   logic          rd_a_req, rd_b_req;
   logic [AW-1:0] rd_a_addr, rd_b_addr;
   logic [DW-1:0] rd_a_data, rd_b_data;
   logic          rd_a_valid, rd_b_valid;
   logic [DEPTH-1:0] written;
   logic          dump_start, dump_ready;
   logic          dump_valid, dump_busy, dump_done;
   logic [DW-1:0] dump_data;
   logic [AW-1:0] dump_idx;

   int n_chk  = 0;
   int n_fail = 0;

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_addr    (wr_addr),
      .wr_enable  (wr_enable),
      .wr_data    (wr_data),
      .rd_a_req   (rd_a_req),
      .rd_a_addr  (rd_a_addr),
      .rd_b_req   (rd_b_req),
      .rd_b_addr  (rd_b_addr),
      .rd_a_data  (rd_a_data),
      .rd_a_valid (rd_a_valid),
      .rd_b_data  (rd_b_data),
      .rd_b_valid (rd_b_valid),
      .written    (written),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .dump_valid (dump_valid),
      .dump_data  (dump_data),
      .dump_idx   (dump_idx),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0]    m_mem [DEPTH];
   logic [DEPTH-1:0] m_written;
   logic             m_a_v, m_b_v;
   logic [DW-1:0]    m_a_d, m_b_d, m_ddata;
   int               m_pos;   // -1 idle, 0..DEPTH-1 beat index, DEPTH done
   int               m_didx;

   function automatic logic [DW-1:0] rv(input int a);
`ifdef REGFILE_BYPASS_EN
      if (wr_enable && (int'(wr_addr) == a)) return wr_data;
`endif
      return m_mem[a];
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_written = '0;
         m_a_v = 1'b0; m_b_v = 1'b0;
         m_a_d = '0;   m_b_d = '0;
         m_pos = -1;   m_didx = 0; m_ddata = '0;
      end else begin
         m_a_v = rd_a_req;
         m_b_v = rd_b_req;
         if (rd_a_req) m_a_d = rv(int'(rd_a_addr));
         if (rd_b_req) m_b_d = rv(int'(rd_b_addr));
         if (m_pos < 0) begin
            if (dump_start) begin
               m_pos = 0; m_didx = 0; m_ddata = rv(0);
            end
         end else if (m_pos < DEPTH) begin
            if (dump_ready) begin
               m_pos++;
               if (m_pos < DEPTH) begin
                  m_didx = m_pos; m_ddata = rv(m_pos);
               end
            end
         end else begin
            m_pos = -1;
         end
         if (wr_enable) begin
            m_mem[wr_addr]     = wr_data;
            m_written[wr_addr] = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model while out of reset.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         chk("rd_a_valid", 32'(rd_a_valid), 32'(m_a_v));
         chk("rd_a_data",  32'(rd_a_data),  32'(m_a_d));
         chk("rd_b_valid", 32'(rd_b_valid), 32'(m_b_v));
         chk("rd_b_data",  32'(rd_b_data),  32'(m_b_d));
         chk("written",    32'(written),    32'(m_written));
         chk("dump_valid", 32'(dump_valid), 32'(m_pos >= 0 && m_pos < DEPTH));
         chk("dump_busy",  32'(dump_busy),  32'(m_pos >= 0));
         chk("dump_done",  32'(dump_done),  32'(m_pos == DEPTH));
         chk("dump_idx",   32'(dump_idx),   32'(m_didx));
         chk("dump_data",  32'(dump_data),  32'(m_ddata));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      reset_n = 1'b0; wr_enable = 1'b0; wr_addr = '0; wr_data = '0;
      rd_a_req = 1'b0; rd_a_addr = '0; rd_b_req = 1'b0; rd_b_addr = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      #2;
      chk("rst_written", 32'(written), 32'h0);
      chk("rst_busy", 32'(dump_busy), 32'h0);
      chk("rst_rd_a_valid", 32'(rd_a_valid), 32'h0);
      tick(); tick();
      reset_n = 1'b1;

      // Write then read r3.
      wr_enable = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
      tick();
      wr_enable = 1'b0; rd_a_req = 1'b1; rd_a_addr = 3'd3;
      tick();
      rd_a_req = 1'b0;
      chk("r3_valid", 32'(rd_a_valid), 32'h1);
      chk("r3_data", 32'(rd_a_data), 32'hA5);
      chk("r3_written", 32'(written), 32'h08);
      tick();
      chk("r3_valid_drop", 32'(rd_a_valid), 32'h0);
      chk("r3_data_hold", 32'(rd_a_data), 32'hA5);

      // Same-edge read/write of r5 on both ports.
      wr_enable = 1'b1; wr_addr = 3'd5; wr_data = 8'h11;
      tick();
      wr_data = 8'h22; rd_b_req = 1'b1; rd_b_addr = 3'd5; rd_a_req = 1'b1; rd_a_addr = 3'd5;
      tick();
      wr_enable = 1'b0; rd_a_req = 1'b0;
      chk("raw_b_data", 32'(rd_b_data), 32'(EXP_RAW_B));
      chk("raw_a_data", 32'(rd_a_data), 32'(EXP_RAW_B));
      chk("raw_b_valid", 32'(rd_b_valid), 32'h1);
      tick();
      rd_b_req = 1'b0;
      chk("r5_after", 32'(rd_b_data), 32'h22);

      // Fill r0..r7 and dump with ready tied high.
      for (int i = 0; i < DEPTH; i++) begin
         wr_enable = 1'b1; wr_addr = AW'(i); wr_data = DW'(8'h10 + i);
         tick();
      end
      wr_enable = 1'b0;
      chk("all_written", 32'(written), 32'hFF);
      dump_ready = 1'b1; dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         chk("beat_valid", 32'(dump_valid), 32'h1);
         chk("beat_idx", 32'(dump_idx), 32'(i));
         chk("beat_data", 32'(dump_data), 32'(8'h10 + i));
         tick();
      end
      chk("done_pulse", 32'(dump_done), 32'h1);
      chk("done_busy", 32'(dump_busy), 32'h1);
      chk("done_valid", 32'(dump_valid), 32'h0);
      tick();
      chk("done_clear", 32'(dump_done), 32'h0);
      chk("busy_clear", 32'(dump_busy), 32'h0);

      // Stall at idx 2 while r2 is rewritten and dump_start is re-pulsed.
      dump_ready = 1'b0; dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      chk("stall_idx0", 32'(dump_idx), 32'h0);
      dump_ready = 1'b1;
      tick(); tick();
      dump_ready = 1'b0;
      chk("stall_idx2", 32'(dump_idx), 32'h2);
      chk("stall_data2", 32'(dump_data), 32'h12);
      wr_enable = 1'b1; wr_addr = 3'd2; wr_data = 8'hFF; dump_start = 1'b1;
      tick();
      wr_enable = 1'b0; dump_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("stall_hold_idx", 32'(dump_idx), 32'h2);
         chk("stall_hold_data", 32'(dump_data), 32'h12);
         tick();
      end
      // Accept idx 2 while writing slot 3 on the edge that loads it.
      dump_ready = 1'b1; wr_enable = 1'b1; wr_addr = 3'd3; wr_data = 8'h33;
      tick();
      wr_enable = 1'b0;
      chk("load3_idx", 32'(dump_idx), 32'h3);
      chk("load3_data", 32'(dump_data), 32'(EXP_LOAD_3));
      tick(); tick(); tick(); tick();
      chk("idx7_data", 32'(dump_data), 32'h17);
      tick();
      chk("done2_pulse", 32'(dump_done), 32'h1);
      tick();
      chk("no_restart", 32'(dump_busy), 32'h0);

      // Reset in the middle of beat 4.
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      tick(); tick(); tick(); tick();
      chk("pre_rst_idx", 32'(dump_idx), 32'h4);
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(dump_valid), 32'h0);
      chk("arst_data", 32'(dump_data), 32'h0);
      chk("arst_idx", 32'(dump_idx), 32'h0);
      chk("arst_busy", 32'(dump_busy), 32'h0);
      chk("arst_done", 32'(dump_done), 32'h0);
      chk("arst_written", 32'(written), 32'h0);
      chk("arst_rd_a_data", 32'(rd_a_data), 32'h0);
      chk("arst_rd_b_data", 32'(rd_b_data), 32'h0);
      tick();
      chk("arst_no_done", 32'(dump_done), 32'h0);
      tick();
      reset_n = 1'b1; dump_start = 1'b1; dump_ready = 1'b1;
      tick();
      dump_start = 1'b0;
      chk("restart_valid", 32'(dump_valid), 32'h1);
      chk("restart_idx", 32'(dump_idx), 32'h0);
      chk("restart_data", 32'(dump_data), 32'h0);
      for (int k = 0; k < 10; k++) tick();
      chk("final_idle", 32'(dump_busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
